// File: rtl/first_layer_par.sv
// Binary-weight first layer: accumulates PAR unsigned features per cycle into
// HIDDEN_CNT signed sums and emits one sign bit per neuron, valid/ready on both sides.
module first_layer_par #(
  parameter int unsigned FEAT_CNT   = 4,
  parameter int unsigned FEAT_BITS  = 4,
  parameter int unsigned HIDDEN_CNT = 4,
  parameter int unsigned PAR        = 1,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] WEIGHTS = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HIDDEN_CNT-1:0]         hidden
);

  localparam int unsigned STEPS = (FEAT_CNT + PAR - 1) / PAR;
  localparam int unsigned ACC_W = FEAT_BITS + $clog2(FEAT_CNT + 1) + 1;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_next;
  logic [CNT_W-1:0]              cnt;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic signed [ACC_W-1:0]       acc      [HIDDEN_CNT];
  logic signed [ACC_W-1:0]       sum_next [HIDDEN_CNT];
  logic                          last_step;

  assign in_ready  = (state == IDLE);
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lanes past FEAT_CNT (only possible in the final step) contribute nothing.
  always_comb begin
    for (int unsigned i = 0; i < HIDDEN_CNT; i++) begin
      sum_next[i] = acc[i];
      for (int unsigned l = 0; l < PAR; l++) begin
        int unsigned             j;
        logic [FEAT_BITS-1:0]    f;
        logic signed [ACC_W-1:0] term;
        j    = 32'(cnt) * PAR + l;
        f    = '0;
        term = '0;
        if (j < FEAT_CNT) begin
          f    = feat_q[j*FEAT_BITS +: FEAT_BITS];
          term = signed'(ACC_W'(f));
          if (WEIGHTS[j*HIDDEN_CNT + i]) sum_next[i] = sum_next[i] + term;
          else                           sum_next[i] = sum_next[i] - term;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      feat_q    <= '0;
      out_valid <= 1'b0;
      hidden    <= '0;
      for (int unsigned i = 0; i < HIDDEN_CNT; i++) acc[i] <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (in_valid) begin
          feat_q <= features;
          cnt    <= '0;
          for (int unsigned i = 0; i < HIDDEN_CNT; i++) acc[i] <= '0;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          for (int unsigned i = 0; i < HIDDEN_CNT; i++) acc[i] <= sum_next[i];
          if (last_step) begin
            out_valid <= 1'b1;
            for (int unsigned i = 0; i < HIDDEN_CNT; i++)
              hidden[i] <= ~sum_next[i][ACC_W-1];
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_first_layer_par.sv
// Randomized self-checking bench for first_layer_par: two configurations
// (4 features x2 lanes, and 5 features x2 lanes with padding) against a sum-of-signs model.
module tb_first_layer_par;

  logic        clk = 1'b0;
  logic        rst, sel, iv, ordy;
  logic [19:0] feat;
  logic        ir_a, ov_a, ir_b, ov_b;
  logic [1:0]  h_a, h_b;
  logic        ir, ov;
  logic [1:0]  h;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  first_layer_par #(
    .FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(2), .PAR(2), .WEIGHTS(8'b01010101)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv & ~sel), .in_ready(ir_a),
    .features(feat[15:0]), .out_valid(ov_a), .out_ready(ordy & ~sel), .hidden(h_a)
  );

  first_layer_par #(
    .FEAT_CNT(5), .FEAT_BITS(4), .HIDDEN_CNT(2), .PAR(2), .WEIGHTS(10'h3FF)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv & sel), .in_ready(ir_b),
    .features(feat), .out_valid(ov_b), .out_ready(ordy & sel), .hidden(h_b)
  );

  assign ir = sel ? ir_b : ir_a;
  assign ov = sel ? ov_b : ov_a;
  assign h  = sel ? h_b  : h_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: hidden[i] = (sum_j +/-feature_j >= 0), sign chosen by weight bit j*2+i.
  function automatic logic [1:0] model(input logic [19:0] f, input bit b);
    logic [1:0] r;
    int fc;
    logic [9:0] w;
    fc = b ? 5 : 4;
    w  = b ? 10'h3FF : 10'h055;
    for (int i = 0; i < 2; i++) begin
      int s = 0;
      for (int j = 0; j < fc; j++) begin
        int v = int'(f[j*4 +: 4]);
        s += w[j*2 + i] ? v : -v;
      end
      r[i] = (s >= 0);
    end
    return r;
  endfunction

  task automatic run_one(input string tag, input logic [19:0] f,
                         input logic [1:0] exp, input int hold);
    int lat;
    int steps;
    steps = sel ? 3 : 2;
    feat = f;
    iv   = 1'b1;
    @(posedge clk); #1;
    iv   = 1'b0;
    feat = 20'($urandom);
    check({tag, "_busy"}, 32'(ir), 32'(0));
    lat = 0;
    while (!ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(steps));
    check({tag, "_hidden"}, 32'(h), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(ov), 32'(1));
      check({tag, "_hold_hidden"}, 32'(h), 32'(exp));
      check({tag, "_hold_ready"}, 32'(ir), 32'(0));
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "_ack_valid"}, 32'(ov), 32'(0));
    check({tag, "_ack_ready"}, 32'(ir), 32'(1));
    check({tag, "_ack_hidden"}, 32'(h), 32'(exp));
  endtask

  // Continuous in_valid/out_ready: every accepted sample must come out in order,
  // with exactly STEPS+2 cycles between results.
  task automatic stream(input string tag, input int cycles);
    logic [1:0] q[$];
    int last_t;
    int gap;
    gap    = sel ? 5 : 4;
    last_t = -1;
    ordy   = 1'b1;
    for (int t = 0; t < cycles + 10; t++) begin
      iv   = (t < cycles);
      feat = 20'($urandom);
      if (iv && ir) q.push_back(model(feat, sel));
      @(posedge clk); #1;
      if (ov) begin
        if (q.size() == 0) check({tag, "_spurious"}, 32'(1), 32'(0));
        else check({tag, "_hidden"}, 32'(h), 32'(q.pop_front()));
        if (last_t >= 0) check({tag, "_gap"}, 32'(t - last_t), 32'(gap));
        last_t = t;
      end
    end
    iv   = 1'b0;
    ordy = 1'b0;
    check({tag, "_drained"}, 32'(q.size()), 32'(0));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; iv = 1'b0; ordy = 1'b0; feat = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(ov), 32'(0));
    check("rst_hidden", 32'(h), 32'(0));
    check("rst_ready", 32'(ir), 32'(1));

    run_one("t1_fives", 20'h05555, 2'b01, 0);
    run_one("t2_zeros", 20'h00000, 2'b11, 0);
    run_one("t3_max", 20'h0FFFF, 2'b01, 0);
    begin
      logic [19:0] f = 20'($urandom);
      run_one("t4_backpressure", f, model(f, 1'b0), 10);
    end
    for (int n = 0; n < 8; n++) begin
      logic [19:0] f = 20'($urandom);
      run_one("rand_a", f, model(f, 1'b0), int'($urandom_range(0, 3)));
    end

    // Reset after the first RUN step must discard the sample.
    run_one("t6_pre", 20'h05555, 2'b01, 0);
    feat = 20'h0FFFF;
    iv   = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_valid", 32'(ov), 32'(0));
    check("t6_hidden", 32'(h), 32'(0));
    check("t6_ready", 32'(ir), 32'(1));
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_discarded", 32'(ov), 32'(0));
    end
    run_one("t6_post", 20'h05555, 2'b01, 0);

    stream("stream_a", 40);

    sel = 1'b1;
    #1;
    check("b_idle_ready", 32'(ir), 32'(1));
    run_one("t5_padded", 20'h54321, 2'b11, 0);
    for (int n = 0; n < 4; n++) begin
      logic [19:0] f = 20'($urandom);
      run_one("rand_b", f, model(f, 1'b1), int'($urandom_range(0, 2)));
    end
    stream("stream_b", 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
